load_store_unit: RTL and testbench
==================================

# load_store_unit

Sits between the CPU datapath and the word-organised data memory port (dataAddr/dataIn/dataOut/regWE). Accepts byte-addressed load/store requests of byte, halfword or word size and handles sub-word access. Loads are extracted and sign/zero-extended; sub-word stores use a read-modify-write sequence, because the memory port writes whole 32-bit words only. A valid/ready request channel and a valid/ready response channel let the control FSM stall on memory operations.

## Interface
- ADDR_W, 10, word-address width of the data memory port
- DATA_W, 32, data width; fixed at 32, other values unsupported
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = reserved
- req_signed  in  1  sign-extend loads (ignored for stores and word loads)
- req_addr  in  ADDR_W+2  byte address
- req_wdata  in  32  store data, right-justified
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer takes response
- rsp_rdata  out  32  load result; 0 for stores and errors
- rsp_err  out  1  misaligned or reserved-size request
- mem_addr  out  ADDR_W  word address to memory (dataAddr)
- mem_we  out  1  write enable to memory (regWE)
- mem_wdata  out  32  write data to memory (dataIn)
- mem_rdata  in  32  combinational read data from memory (dataOut)

## Operation
- Byte order is little-endian: byte at offset 0 is bits 7:0; the halfword at offset 2 is bits 31:16.
- FSM states:
  - IDLE: req_ready=1. On req_valid, capture the request.
    - Error request → RESP.
    - Otherwise → ACCESS.
  - ACCESS: mem_addr = captured address[ADDR_W+1:2].
    - Load: extract the lane from mem_rdata, extend it, register it → RESP.
    - Word store: mem_we=1, mem_wdata=req_wdata → RESP.
    - Sub-word store: register merged word (mem_rdata with the addressed lane replaced) → WRITE.
  - WRITE: mem_we=1, mem_wdata = merged word, same mem_addr → RESP.
  - RESP: rsp_valid=1; outputs stay stable until rsp_ready. The cycle with rsp_valid && rsp_ready → IDLE.
- Error rules:
  - Half with addr[0]=1 is an error.
  - Word with addr[1:0]≠0 is an error.
  - size=3 is an error.
  - An error request never touches memory: mem_we stays 0, rsp_err=1, rsp_rdata=0.
- Loads: byte/half are zero-extended, or sign-extended when req_signed=1.
- mem_we is asserted only in ACCESS (word store) or WRITE, for exactly one cycle per store.
- mem_addr and mem_wdata are 0 in IDLE.

## Timing
- Reset (rst_n low, takes effect immediately): state IDLE.
  - Outputs 0: req_ready, rsp_valid, rsp_rdata, rsp_err, mem_we, mem_addr, mem_wdata.
  - req_ready rises only after rst_n deasserts.
- Accept at edge E0 → ACCESS during cycle after E0.
- Load and word store: rsp_valid from E2.
- Sub-word store: rsp_valid from E3. The memory write lands on the edge ending the WRITE cycle.
- Error request: rsp_valid from E1.
- Back-to-back requests: the next request is accepted no earlier than the edge after the response handshake. Minimum 3 cycles per load.
- req_valid while not in IDLE is ignored; the request is not captured.
- rst_n asserted in ACCESS or WRITE: mem_we drops asynchronously, the operation is abandoned, and no response is issued.

## Configuration
- LSU_ALIGN_CHECK_EN defined: misalignment and reserved-size checks are active as above.
- Undefined:
  - rsp_err is tied 0.
  - Misaligned addresses are force-aligned (half ignores addr[0]; word ignores addr[1:0]).
  - size=3 is treated as word.
  - All requests go to ACCESS.

## Structure
- Package lsu_pkg:
  - Size encodings SZ_BYTE/SZ_HALF/SZ_WORD.
  - State enum lsu_state_t (IDLE, ACCESS, WRITE, RESP).
  - Misalignment-check function.
- Sub-module lsu_lane, combinational and shared by the load and store paths:
  - Extract/extend (inputs: word, offset, size, signed).
  - Merge (inputs: old word, new data, offset, size).

## Test plan
- Memory word 0x11223344 at word 4. Load byte, addr 0x011, signed → rsp_rdata 0x00000033, rsp_valid at E2.
- Memory word 0x8000F0FF at word 4:
  - Half load, addr 0x012, signed → 0xFFFF8000.
  - Same access with req_signed=0 → 0x00008000.
- Memory word 0xAABBCCDD at word 5. Store byte 0x5A, addr 0x016:
  - One mem_we pulse in WRITE.
  - Memory word 5 becomes 0xAA5ACCDD.
  - rsp_valid at E3.
- Word store 0xDEADBEEF to addr 0x020 → single mem_we in ACCESS, word 8 = 0xDEADBEEF.
- Half load to addr 0x013:
  - With LSU_ALIGN_CHECK_EN: rsp_err=1, rdata 0, no mem_we, rsp_valid at E1.
  - Without it: aligned read of bytes 2–3.
- Hold rsp_ready low for 5 cycles → rsp outputs stable and req_ready=0. Then assert rst_n low during a WRITE cycle → mem_we=0 immediately, all outputs 0.

Source files
------------

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared encodings, FSM state type and address-check helpers
// for the load/store unit.
package lsu_pkg;

  // Access size encodings carried on req_size
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic [1:0] SZ_RSVD = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WRITE  = 2'd2,
    RESP   = 2'd3
  } lsu_state_t;

  // True when the size/offset pair cannot be served (misaligned or reserved size)
  function automatic logic isMisaligned(input logic [1:0] size, input logic [1:0] offset);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = offset[0];
      SZ_WORD: bad = (offset != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Reserved size collapses onto a word access when checking is disabled
  function automatic logic [1:0] normSize(input logic [1:0] size);
    logic [1:0] sz;
    if (size == SZ_RSVD) begin
      sz = SZ_WORD;
    end else begin
      sz = size;
    end
    return sz;
  endfunction

  // Drop the low offset bits that a given size cannot address
  function automatic logic [1:0] alignOffset(input logic [1:0] size, input logic [1:0] offset);
    logic [1:0] off;
    case (size)
      SZ_BYTE: off = offset;
      SZ_HALF: off = {offset[1], 1'b0};
      default: off = 2'b00;
    endcase
    return off;
  endfunction

endpackage

// File: rtl/lsu_lane.sv
// lsu_lane: combinational byte-lane logic shared by the load and store paths.
// Loads pick the addressed lane out of a memory word and extend it; stores
// splice the new data into the old word so a full word can be written back.
module lsu_lane
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        isSigned,
  input  logic [31:0] newData,
  output logic [31:0] loadData,
  output logic [31:0] mergedWord
);

  logic [7:0]  byteSel_s;
  logic [15:0] halfSel_s;

  // Lane extraction and sign/zero extension for loads
  always_comb begin
    byteSel_s = 8'h00;
    halfSel_s = 16'h0000;
    loadData  = 32'h0000_0000;
    case (offset)
      2'd0:    byteSel_s = word[7:0];
      2'd1:    byteSel_s = word[15:8];
      2'd2:    byteSel_s = word[23:16];
      2'd3:    byteSel_s = word[31:24];
      default: byteSel_s = 8'h00;
    endcase
    if (offset[1]) begin
      halfSel_s = word[31:16];
    end else begin
      halfSel_s = word[15:0];
    end
    case (size)
      SZ_BYTE: loadData = {{24{isSigned & byteSel_s[7]}}, byteSel_s};
      SZ_HALF: loadData = {{16{isSigned & halfSel_s[15]}}, halfSel_s};
      default: loadData = word;
    endcase
  end

  // Replace the addressed lane of the old word with the new store data
  always_comb begin
    mergedWord = word;
    case (size)
      SZ_BYTE: begin
        case (offset)
          2'd0:    mergedWord[7:0]   = newData[7:0];
          2'd1:    mergedWord[15:8]  = newData[7:0];
          2'd2:    mergedWord[23:16] = newData[7:0];
          2'd3:    mergedWord[31:24] = newData[7:0];
          default: mergedWord        = word;
        endcase
      end
      SZ_HALF: begin
        if (offset[1]) begin
          mergedWord[31:16] = newData[15:0];
        end else begin
          mergedWord[15:0] = newData[15:0];
        end
      end
      default: mergedWord = newData;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: byte-addressed load/store front end for a word-wide data
// memory. Sub-word stores use read-modify-write; loads are extended.
// Optional build macro LSU_ALIGN_CHECK_EN: report misaligned and
// reserved-size requests as errors instead of force-aligning them.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W+1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  lsu_state_t        state_r;
  lsu_state_t        nextState_s;
  logic              accept_s;
  logic              reqErr_s;
  logic [1:0]        reqSize_s;
  logic [1:0]        reqOff_s;
  logic              capWrite_r;
  logic              capSigned_r;
  logic [1:0]        capSize_r;
  logic [1:0]        capOff_r;
  logic [DATA_W-1:0] capWdata_r;
  logic [DATA_W-1:0] loadData_s;
  logic [DATA_W-1:0] mergedWord_s;

  assign accept_s = (state_r == IDLE) && req_ready && req_valid;

  // Classify the incoming request: error flag plus effective size/offset
  always_comb begin
    reqErr_s  = 1'b0;
    reqSize_s = req_size;
    reqOff_s  = req_addr[1:0];
`ifdef LSU_ALIGN_CHECK_EN
    reqErr_s  = isMisaligned(req_size, req_addr[1:0]);
`else
    reqSize_s = normSize(req_size);
    reqOff_s  = alignOffset(normSize(req_size), req_addr[1:0]);
`endif
  end

  lsu_lane u_lane (
    .word       (mem_rdata),
    .offset     (capOff_r),
    .size       (capSize_r),
    .isSigned   (capSigned_r),
    .newData    (capWdata_r),
    .loadData   (loadData_s),
    .mergedWord (mergedWord_s)
  );

  // Next-state selection
  always_comb begin
    nextState_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          if (reqErr_s) begin
            nextState_s = RESP;
          end else begin
            nextState_s = ACCESS;
          end
        end else begin
          nextState_s = IDLE;
        end
      end
      ACCESS: begin
        if (capWrite_r && (capSize_r != SZ_WORD)) begin
          nextState_s = WRITE;
        end else begin
          nextState_s = RESP;
        end
      end
      WRITE: nextState_s = RESP;
      RESP: begin
        if (rsp_valid && rsp_ready) begin
          nextState_s = IDLE;
        end else begin
          nextState_s = RESP;
        end
      end
      default: nextState_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= nextState_s;
    end
  end

  // Latch the request fields at acceptance so later states ignore the bus
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      capWrite_r  <= 1'b0;
      capSigned_r <= 1'b0;
      capSize_r   <= SZ_BYTE;
      capOff_r    <= 2'b00;
      capWdata_r  <= {DATA_W{1'b0}};
    end else if (accept_s) begin
      capWrite_r  <= req_write;
      capSigned_r <= req_signed;
      capSize_r   <= reqSize_s;
      capOff_r    <= reqOff_s;
      capWdata_r  <= req_wdata;
    end else begin
      capWrite_r  <= capWrite_r;
      capSigned_r <= capSigned_r;
      capSize_r   <= capSize_r;
      capOff_r    <= capOff_r;
      capWdata_r  <= capWdata_r;
    end
  end

  // Registered outputs, loaded with the values belonging to the state being entered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= {DATA_W{1'b0}};
      rsp_err   <= 1'b0;
      mem_addr  <= {ADDR_W{1'b0}};
      mem_we    <= 1'b0;
      mem_wdata <= {DATA_W{1'b0}};
    end else begin
      req_ready <= (nextState_s == IDLE);
      rsp_valid <= (nextState_s == RESP);
      case (nextState_s)
        IDLE: begin
          mem_addr  <= {ADDR_W{1'b0}};
          mem_we    <= 1'b0;
          mem_wdata <= {DATA_W{1'b0}};
          rsp_rdata <= {DATA_W{1'b0}};
          rsp_err   <= 1'b0;
        end
        ACCESS: begin
          // Word stores write straight away; everything else only reads here
          mem_addr <= req_addr[ADDR_W+1:2];
          mem_we   <= req_write && (reqSize_s == SZ_WORD);
          if (req_write && (reqSize_s == SZ_WORD)) begin
            mem_wdata <= req_wdata;
          end else begin
            mem_wdata <= {DATA_W{1'b0}};
          end
          rsp_rdata <= {DATA_W{1'b0}};
          rsp_err   <= 1'b0;
        end
        WRITE: begin
          mem_addr  <= mem_addr;
          mem_we    <= 1'b1;
          mem_wdata <= mergedWord_s;
          rsp_rdata <= {DATA_W{1'b0}};
          rsp_err   <= 1'b0;
        end
        RESP: begin
          mem_addr  <= {ADDR_W{1'b0}};
          mem_we    <= 1'b0;
          mem_wdata <= {DATA_W{1'b0}};
          if (state_r == IDLE) begin
            rsp_rdata <= {DATA_W{1'b0}};
            rsp_err   <= reqErr_s;
          end else if (state_r == RESP) begin
            rsp_rdata <= rsp_rdata;
            rsp_err   <= rsp_err;
          end else begin
            // Leaving ACCESS or WRITE: only loads return data
            if (capWrite_r) begin
              rsp_rdata <= {DATA_W{1'b0}};
            end else begin
              rsp_rdata <= loadData_s;
            end
            rsp_err <= 1'b0;
          end
        end
        default: begin
          mem_addr  <= {ADDR_W{1'b0}};
          mem_we    <= 1'b0;
          mem_wdata <= {DATA_W{1'b0}};
          rsp_rdata <= {DATA_W{1'b0}};
          rsp_err   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed plus randomized requests against a word
// memory, checked with a byte-level reference model kept in the bench.
module tb_load_store_unit;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W+1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic [31:0] mem    [0:1023];
  logic [31:0] refMem [0:1023];

  int checks = 0;
  int failures = 0;
  int weCount = 0;
  int edgeCnt = 0;
  int lastWeEdge = 0;

  load_store_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];

  // Data memory: combinational read, write on the clock edge; also logs write pulses
  always @(posedge clk) begin
    edgeCnt <= edgeCnt + 1;
    if (mem_we === 1'b1) begin
      mem[mem_addr] <= mem_wdata;
      weCount       <= weCount + 1;
      lastWeEdge    <= edgeCnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference behaviour in byte terms: returns error, load result, response
  // latency in cycles after acceptance, and number of memory writes; stores update refMem.
  task automatic refModel(input logic wr, input logic [1:0] sz, input logic sg,
                          input logic [11:0] addr, input logic [31:0] wd,
                          output logic err, output logic [31:0] rd,
                          output int lat, output int nWe);
    int nBytes;
    int off;
    int w;
    logic [63:0] mask;
    logic [63:0] v;
    w = int'(addr[11:2]);
    off = int'(addr[1:0]);
    nBytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
`ifdef LSU_ALIGN_CHECK_EN
    err = (sz == 2'd3) || ((off % nBytes) != 0);
`else
    err = 1'b0;
    off = off - (off % nBytes);
`endif
    rd = 32'd0;
    lat = 1;
    nWe = 0;
    mask = (64'd1 << (8 * nBytes)) - 64'd1;
    if (!err && !wr) begin
      v = ({32'd0, refMem[w]} >> (8 * off)) & mask;
      if (sg && (nBytes < 4) && v[8 * nBytes - 1]) v = v | ~mask;
      rd = v[31:0];
      lat = 2;
    end else if (!err && wr) begin
      v = ({32'd0, refMem[w]} & ~(mask << (8 * off))) | (({32'd0, wd} & mask) << (8 * off));
      refMem[w] = v[31:0];
      lat = (nBytes == 4) ? 2 : 3;
      nWe = 1;
    end
  endtask

  // One complete request: issue, time the response, hold it, handshake, verify memory
  task automatic runReq(input string tag, input logic wr, input logic [1:0] sz, input logic sg,
                        input logic [11:0] addr, input logic [31:0] wd,
                        input int hold, input bit poke);
    logic expErr;
    logic [31:0] expRd;
    int expLat;
    int expWe;
    int we0;
    int acc;
    int lat;
    bit got;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = (req_ready === 1'b1);
    end
    check({tag, ".ready"}, 32'(got), 32'd1);
    refModel(wr, sz, sg, addr, wd, expErr, expRd, expLat, expWe);
    we0 = weCount;
    req_valid = 1'b1; req_write = wr; req_size = sz; req_signed = sg;
    req_addr = addr; req_wdata = wd;
    @(posedge clk);
    #1;
    acc = edgeCnt;
    req_valid = 1'b0; req_write = ~wr; req_size = 2'($urandom_range(0, 3));
    req_addr = 12'($urandom); req_wdata = $urandom;
    lat = 0;
    for (int n = 1; n <= 10 && lat == 0; n++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) lat = n;
    end
    check({tag, ".latency"}, 32'(lat), 32'(expLat));
    check({tag, ".rdata"}, rsp_rdata, expRd);
    check({tag, ".err"}, 32'(rsp_err), 32'(expErr));
    check({tag, ".busy"}, 32'(req_ready), 32'd0);
    for (int h = 0; h < hold; h++) begin
      if (poke) begin
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd2;
        req_addr = addr; req_wdata = ~wd;
      end
      @(negedge clk);
      check({tag, ".hold_valid"}, 32'(rsp_valid), 32'd1);
      check({tag, ".hold_rdata"}, rsp_rdata, expRd);
      check({tag, ".hold_err"}, 32'(rsp_err), 32'(expErr));
      check({tag, ".hold_ready"}, 32'(req_ready), 32'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    check({tag, ".rsp_drop"}, 32'(rsp_valid), 32'd0);
    check({tag, ".we_count"}, 32'(weCount - we0), 32'(expWe));
    if (expWe != 0) check({tag, ".we_edge"}, 32'(lastWeEdge - acc), 32'(expLat - 1));
    check({tag, ".mem"}, mem[addr[11:2]], refMem[addr[11:2]]);
  endtask

  initial begin
    logic [31:0] v;
    logic [11:0] a;
    int stallSeen;
    for (int i = 0; i < 1024; i++) begin
      v = $urandom;
      mem[i] <= v;
      refMem[i] = v;
    end
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
    req_signed = 1'b0; req_addr = 12'd0; req_wdata = 32'd0; rsp_ready = 1'b0;
    #1;
    check("rst.req_ready", 32'(req_ready), 32'd0);
    check("rst.rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst.rsp_rdata", rsp_rdata, 32'd0);
    check("rst.rsp_err", 32'(rsp_err), 32'd0);
    check("rst.mem_we", 32'(mem_we), 32'd0);
    check("rst.mem_addr", 32'(mem_addr), 32'd0);
    check("rst.mem_wdata", mem_wdata, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst.ready_after_release", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    check("idle.ready", 32'(req_ready), 32'd1);
    check("idle.mem_addr", 32'(mem_addr), 32'd0);

    // Directed cases from the documented scenarios
    mem[4] <= 32'h11223344; refMem[4] = 32'h11223344;
    runReq("ldb_s", 1'b0, 2'd0, 1'b1, 12'h011, 32'd0, 0, 1'b0);
    mem[4] <= 32'h8000F0FF; refMem[4] = 32'h8000F0FF;
    runReq("ldh_s", 1'b0, 2'd1, 1'b1, 12'h012, 32'd0, 0, 1'b0);
    runReq("ldh_u", 1'b0, 2'd1, 1'b0, 12'h012, 32'd0, 1, 1'b0);
    mem[5] <= 32'hAABBCCDD; refMem[5] = 32'hAABBCCDD;
    runReq("stb", 1'b1, 2'd0, 1'b0, 12'h016, 32'h0000005A, 0, 1'b0);
    check("stb.literal", mem[5], 32'hAA5ACCDD);
    runReq("stw", 1'b1, 2'd2, 1'b0, 12'h020, 32'hDEADBEEF, 0, 1'b0);
    check("stw.literal", mem[8], 32'hDEADBEEF);
    runReq("ldh_mis", 1'b0, 2'd1, 1'b1, 12'h013, 32'd0, 5, 1'b1);
    runReq("sth_hi", 1'b1, 2'd1, 1'b0, 12'h01E, 32'h1234ABCD, 2, 1'b1);
    runReq("ld_rsvd", 1'b0, 2'd3, 1'b0, 12'h024, 32'd0, 0, 1'b0);

    // Randomized traffic over a small window of words
    for (int t = 0; t < 40; t++) begin
      a = 12'($urandom_range(0, 63));
      runReq("rnd", 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), a, $urandom, $urandom_range(0, 2), 1'b0);
    end

    // Reset in the middle of a read-modify-write abandons it
    mem[6] <= 32'h01020304; refMem[6] = 32'h01020304;
    stallSeen = 0;
    for (int i = 0; i < 20 && stallSeen == 0; i++) begin
      @(negedge clk);
      if (req_ready === 1'b1) stallSeen = 1;
    end
    check("abort.ready", 32'(stallSeen), 32'd1);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0; req_signed = 1'b0;
    req_addr = 12'h018; req_wdata = 32'h000000FF;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    check("abort.we_in_write", 32'(mem_we), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort.mem_we", 32'(mem_we), 32'd0);
    check("abort.req_ready", 32'(req_ready), 32'd0);
    check("abort.rsp_valid", 32'(rsp_valid), 32'd0);
    check("abort.mem_addr", 32'(mem_addr), 32'd0);
    check("abort.mem_wdata", mem_wdata, 32'd0);
    check("abort.rsp_rdata", rsp_rdata, 32'd0);
    check("abort.rsp_err", 32'(rsp_err), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    stallSeen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0) stallSeen = 1;
    end
    check("abort.no_rsp", 32'(stallSeen), 32'd0);
    check("abort.mem", mem[6], 32'h01020304);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
